// File: rtl/ecg_sample_writer.sv
// ECG sample decimator: box-car averages groups of 2^DECIM_LOG2 samples and
// writes each average into a circular display buffer in RAM.
module ecg_sample_writer #(
    parameter logic [11:0] BASE_ADDR  = 12'h801,
    parameter int          DEPTH      = 640,
    parameter int          DECIM_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    input  logic        freeze,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [9:0]  wr_ptr,
    output logic        frame_done
);

    localparam int            AW       = 12 + DECIM_LOG2;
    localparam int            CW       = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);
    localparam logic [9:0]    PTR_LAST = 10'(DEPTH - 1);

    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [11:0]   r_addr;
    logic [11:0]   r_wdata;
    logic [9:0]    r_ptr;
    logic          r_fd;

    logic          w_accept;
    logic          w_group_end;
    logic [AW-1:0] w_sum;
    logic [11:0]   w_avg;
    logic [9:0]    w_ptr_next;

    // Accept qualification, group sum and the pointer as it will be after any
    // write currently on the port, so back-to-back writes get distinct slots.
    always_comb begin
        w_accept    = sample_valid & ~freeze;
        w_group_end = (r_cnt == CNT_LAST);
        w_sum       = r_acc + AW'(sample_in);
        w_avg       = 12'(w_sum >> DECIM_LOG2);
        if (r_we) begin
            if (r_ptr == PTR_LAST) begin
                w_ptr_next = 10'd0;
            end else begin
                w_ptr_next = r_ptr + 10'd1;
            end
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    // Group accumulator; freeze discards any partial group.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (freeze) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (sample_valid) begin
            if (w_group_end) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
        end
    end

    // Write stage and buffer pointer; a loaded write always completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 12'd0;
            r_fd    <= 1'b0;
            r_ptr   <= 10'd0;
        end else begin
            r_ptr <= w_ptr_next;
            if (w_accept && w_group_end) begin
                r_we    <= 1'b1;
                r_addr  <= BASE_ADDR + {2'b00, w_ptr_next};
                r_wdata <= w_avg;
                r_fd    <= (w_ptr_next == PTR_LAST);
            end else begin
                r_we    <= 1'b0;
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
                r_fd    <= 1'b0;
            end
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = {20'd0, r_wdata};
    assign wr_ptr     = r_ptr;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Scoreboard bench for ecg_sample_writer with default parameters.
module tb_ecg_sample_writer;

    logic        clock;
    logic        reset;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        freeze;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [9:0]  wr_ptr;
    logic        frame_done;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        fd;
    } wr_t;

    wr_t q[$];
    int  n_checks;
    int  n_pass;
    int  m_acc;
    int  m_cnt;
    int  m_ptr;
    int  mon_ptr;
    int  fd_seen;

    ecg_sample_writer dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .freeze       (freeze),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .wr_ptr       (wr_ptr),
        .frame_done   (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Drive one cycle of stimulus and update the reference model.
    task automatic cycle(input logic v, input logic [11:0] s, input logic f);
        wr_t e;
        @(negedge clock);
        sample_valid = v;
        sample_in    = s;
        freeze       = f;
        if (f) begin
            m_acc = 0;
            m_cnt = 0;
        end else if (v) begin
            m_acc += int'(s);
            m_cnt++;
            if (m_cnt == 4) begin
                e.addr = 12'(12'h801 + m_ptr);
                e.data = 32'(m_acc / 4);
                e.fd   = (m_ptr == 639);
                q.push_back(e);
                m_ptr = (m_ptr == 639) ? 0 : m_ptr + 1;
                m_acc = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic group4(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d);
        cycle(1'b1, a, 1'b0);
        cycle(1'b1, b, 1'b0);
        cycle(1'b1, c, 1'b0);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 12) begin
            cycle(1'b0, 12'd0, 1'b0);
            n++;
        end
        cycle(1'b0, 12'd0, 1'b0);
        check("drain", 32'(q.size()), 32'd0);
    endtask

    // Monitor: every write must match the oldest expected write.
    always @(negedge clock) begin
        wr_t e;
        if (!reset && mem_we) begin
            if (q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(e.addr));
                check("mem_wdata", mem_wdata, e.data);
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("wr_ptr_at_write", 32'(wr_ptr), 32'(mon_ptr));
                if (frame_done) fd_seen++;
                mon_ptr = (mon_ptr == 639) ? 0 : mon_ptr + 1;
            end
        end
    end

    initial begin
        n_checks = 0; n_pass = 0; m_acc = 0; m_cnt = 0; m_ptr = 0; mon_ptr = 0; fd_seen = 0;
        reset = 1'b1; sample_valid = 1'b0; sample_in = 12'd0; freeze = 1'b0;
        #12;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ptr", 32'(wr_ptr), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h801);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        group4(12'd100, 12'd200, 12'd300, 12'd400);
        drain();
        check("ptr_after_first", 32'(wr_ptr), 32'd1);

        group4(12'd4095, 12'd4095, 12'd4095, 12'd4095);
        group4(12'd1, 12'd1, 12'd1, 12'd2);
        for (int i = 0; i < 20; i++) begin
            group4(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                   12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end
        drain();

        // Partial group discarded by freeze
        cycle(1'b1, 12'd7, 1'b0);
        cycle(1'b1, 12'd9, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 12'd4000, 1'b1);
        group4(12'd80, 12'd80, 12'd80, 12'd80);
        drain();

        // Freeze right after a group completes: that write still issues
        group4(12'd10, 12'd20, 12'd30, 12'd40);
        for (int i = 0; i < 5; i++) cycle(1'b1, 12'd555, 1'b1);
        check("freeze_q_empty", 32'(q.size()), 32'd0);
        check("freeze_ptr_hold", 32'(wr_ptr), 32'(mon_ptr));
        check("freeze_we_idle", 32'(mem_we), 32'd0);
        cycle(1'b0, 12'd0, 1'b0);

        // Reset during the write cycle
        group4(12'd1000, 12'd1000, 12'd1000, 12'd1000);
        @(posedge clock);
        #2;
        check("pre_reset_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_we_drop", 32'(mem_we), 32'd0);
        check("reset_ptr", 32'(wr_ptr), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'h801);
        q.delete();
        m_acc = 0; m_cnt = 0; m_ptr = 0; mon_ptr = 0;
        sample_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        group4(12'd60, 12'd64, 12'd68, 12'd72);
        drain();

        // Full frame wrap
        for (int g = 0; g < 640; g++) begin
            group4(12'(g), 12'(g + 1), 12'(g + 2), 12'(g + 3));
        end
        group4(12'd500, 12'd500, 12'd500, 12'd500);
        drain();
        check("frame_pulses", 32'(fd_seen), 32'd1);
        check("ptr_after_wrap", 32'(wr_ptr), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
